// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character per handshake, looks it up through an
// external encoder and times the resulting marks and gaps. Optional abort input: KEYER_ABORT_EN.
module morse_keyer #(
  parameter int UNIT_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] enc_char,
  input  logic [7:0] enc_morse,
  input  logic [2:0] enc_length,
  output logic       key_out,
  output logic       busy,
  output logic       err
`ifdef KEYER_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MARK  = 3'd2;
  localparam logic [2:0] ST_SPACE = 3'd3;
  localparam logic [2:0] ST_CGAP  = 3'd4;
  localparam logic [2:0] ST_WGAP  = 3'd5;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    logic [7:0] r;
    if (c >= 8'h61 && c <= 8'h7A) begin
      r = c - 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       unit_r;
  logic [7:0]       shift_r;
  logic [2:0]       sym_r;
  logic [7:0]       enc_char_r;
  logic             key_out_r;
  logic             ready_r;
  logic             err_r;
  logic             err_next_s;
  logic             abort_s;
  logic             accept_s;
  logic             tick_s;
  logic             done_s;
  logic [2:0]       dur_s;

`ifdef KEYER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign accept_s   = char_valid & ready_r & ~abort_s;
  assign tick_s     = (cnt_r == UNIT_LAST);
  assign char_ready = ready_r;
  assign busy       = ~ready_r;
  assign key_out    = key_out_r;
  assign err        = err_r;
  assign enc_char   = enc_char_r;

  // Duration of the current state in Morse units; shift_r[7] is the symbol being keyed.
  always_comb begin
    dur_s = 3'd1;
    case (state_r)
      ST_MARK:  dur_s = shift_r[7] ? 3'd3 : 3'd1;
      ST_SPACE: dur_s = 3'd1;
      ST_CGAP:  dur_s = 3'd3;
      ST_WGAP:  dur_s = 3'd4;
      default:  dur_s = 3'd1;
    endcase
    done_s = tick_s && (unit_r == dur_s - 3'd1);
  end

  // Next-state decode; abort outranks everything outside IDLE.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = 1'b0;
    if (abort_s && (state_r != ST_IDLE)) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_next_s = ST_LOAD;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (enc_length != 3'd0) begin
            state_next_s = ST_MARK;
          end else if (enc_char_r == 8'h20) begin
            state_next_s = ST_WGAP;
          end else begin
            state_next_s = ST_IDLE;
            err_next_s   = 1'b1;
          end
        end
        ST_MARK: begin
          if (!done_s) begin
            state_next_s = ST_MARK;
          end else if (sym_r > 3'd1) begin
            state_next_s = ST_SPACE;
          end else begin
            state_next_s = ST_CGAP;
          end
        end
        ST_SPACE: begin
          if (done_s) begin
            state_next_s = ST_MARK;
          end else begin
            state_next_s = ST_SPACE;
          end
        end
        ST_CGAP, ST_WGAP: begin
          if (done_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = state_r;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      key_out_r <= 1'b0;
      ready_r   <= 1'b1;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      key_out_r <= (state_next_s == ST_MARK);
      ready_r   <= (state_next_s == ST_IDLE);
      err_r     <= err_next_s;
    end
  end

  // Character latch with lower-to-upper case folding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_char_r <= 8'h00;
    end else if (accept_s) begin
      enc_char_r <= to_upper(char_in);
    end else begin
      enc_char_r <= enc_char_r;
    end
  end

  // Pattern left-justified so the first symbol sits in bit 7; shifted after each inter-symbol space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 8'h00;
      sym_r   <= 3'd0;
    end else if (state_r == ST_LOAD) begin
      shift_r <= enc_morse << (4'd8 - {1'b0, enc_length});
      sym_r   <= enc_length;
    end else if ((state_r == ST_SPACE) && done_s) begin
      shift_r <= {shift_r[6:0], 1'b0};
      sym_r   <= sym_r - 3'd1;
    end else begin
      shift_r <= shift_r;
      sym_r   <= sym_r;
    end
  end

  // Cycle and unit counters restart on every state entry so each state is a whole number of units.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      unit_r <= 3'd0;
    end else if ((state_r == ST_IDLE) || (state_next_s != state_r)) begin
      cnt_r  <= '0;
      unit_r <= 3'd0;
    end else if (tick_s) begin
      cnt_r  <= '0;
      unit_r <= unit_r + 3'd1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      unit_r <= unit_r;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer with UNIT_CYCLES = 4 and a behavioural encoder.
module tb_morse_keyer;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] enc_char;
  logic [7:0] enc_morse;
  logic [2:0] enc_length;
  logic       key_out;
  logic       busy;
  logic       err;
  logic       abort = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  morse_keyer #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .enc_char   (enc_char),
    .enc_morse  (enc_morse),
    .enc_length (enc_length),
    .key_out    (key_out),
    .busy       (busy),
    .err        (err)
`ifdef KEYER_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  function automatic string morse_of(input logic [7:0] c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  function automatic logic [10:0] encode(input logic [7:0] c);
    string s;
    logic [7:0] m;
    m = 8'h00;
    s = morse_of(c);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") m[s.len() - 1 - i] = 1'b1;
    end
    return {3'(s.len()), m};
  endfunction

  always_comb {enc_length, enc_morse} = encode(enc_char);

  // Runs one character from its acceptance cycle (0) to the cycle ready returns (n).
  task automatic run_char(input logic [7:0] c, input logic [7:0] next_c, input bit hold_in);
    logic [7:0] u;
    string s;
    bit q[$];
    bit bad, hold, exp_key, exp_rdy, exp_err;
    int n;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    s = morse_of(u);
    bad = (u != " ") && (s.len() == 0);
    hold = hold_in && !bad;
    if (u == " ") begin
      repeat (4) q.push_back(1'b0);
    end else if (!bad) begin
      for (int i = 0; i < s.len(); i++) begin
        repeat ((s[i] == "-") ? 3 : 1) q.push_back(1'b1);
        if (i < s.len() - 1) q.push_back(1'b0);
      end
      repeat (3) q.push_back(1'b0);
    end
    n = bad ? 2 : 2 + q.size() * U;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      exp_key = (k >= 2 && k < n) ? q[(k - 2) / U] : 1'b0;
      exp_rdy = (k == 0) || (k == n);
      exp_err = bad && (k == n);
      n_checks++;
      if (key_out !== exp_key) $display("FAIL key_out char=%h cyc=%0d got=%b want=%b", c, k, key_out, exp_key);
      else n_pass++;
      n_checks++;
      if (char_ready !== exp_rdy || busy !== !exp_rdy)
        $display("FAIL ready char=%h cyc=%0d got=%b/%b want=%b", c, k, char_ready, busy, exp_rdy);
      else n_pass++;
      n_checks++;
      if (err !== exp_err) $display("FAIL err char=%h cyc=%0d got=%b want=%b", c, k, err, exp_err);
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if (enc_char !== u) $display("FAIL enc_char char=%h got=%h want=%h", c, enc_char, u);
        else n_pass++;
      end
      if (k == 0) begin
        char_in = c;
        char_valid = 1'b1;
      end else if (hold && k < n) begin
        char_in = next_c;
        char_valid = 1'b1;
      end else begin
        char_valid = 1'b0;
      end
    end
    if (bad) begin
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || char_ready !== 1'b1 || key_out !== 1'b0)
        $display("FAIL err_pulse_end got err=%b rdy=%b key=%b want 0/1/0", err, char_ready, key_out);
      else n_pass++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (key_out !== 1'b0 || char_ready !== 1'b1) $display("FAIL idle got key=%b rdy=%b want 0/1", key_out, char_ready);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (key_out !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || enc_char !== 8'h00)
      $display("FAIL reset_state got key=%b rdy=%b busy=%b err=%b enc=%h want 0/1/0/0/00",
               key_out, char_ready, busy, err, enc_char);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    char_in = "T";
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (key_out !== 1'b1) $display("FAIL mid_dash got=%b want=1", key_out);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_out !== 1'b0 || char_ready !== 1'b1 || enc_char !== 8'h00)
      $display("FAIL async_reset got key=%b rdy=%b enc=%h want 0/1/00", key_out, char_ready, enc_char);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (char_ready !== 1'b1 || err !== 1'b0 || key_out !== 1'b0)
      $display("FAIL after_reset got rdy=%b err=%b key=%b want 1/0/0", char_ready, err, key_out);
    else n_pass++;
  endtask

  task automatic test_letter_e();
    run_char("E", 8'h00, 1'b0);
  endtask

  task automatic test_lowercase_a();
    run_char("a", 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back_space();
    run_char("E", " ", 1'b1);
    run_char(" ", 8'h00, 1'b0);
  endtask

  task automatic test_unsupported();
    run_char("#", 8'h00, 1'b0);
  endtask

`ifdef KEYER_ABORT_EN
  task automatic test_abort();
    char_in = "O";
    char_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      char_valid = 1'b0;
      if (k == 5) begin
        n_checks++;
        if (key_out !== 1'b1) $display("FAIL abort_pre got=%b want=1", key_out);
        else n_pass++;
        abort = 1'b1;
      end
    end
    abort = 1'b0;
    n_checks++;
    if (key_out !== 1'b0 || char_ready !== 1'b1)
      $display("FAIL abort got key=%b rdy=%b want 0/1", key_out, char_ready);
    else n_pass++;
    run_char("T", 8'h00, 1'b0);
  endtask
`endif

  task automatic test_random();
    string charset;
    logic [7:0] seq[16];
    bit hold;
    charset = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefxyz0123456789 #?";
    for (int i = 0; i < 16; i++) seq[i] = charset[$urandom_range(0, charset.len() - 1)];
    for (int i = 0; i < 16; i++) begin
      hold = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_char(seq[i], (i < 15) ? seq[i + 1] : 8'h00, hold);
      if (!hold || morse_of(seq[i]) == "" && seq[i] != " " && !(seq[i] >= "a" && seq[i] <= "z"))
        idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_lowercase_a();
    test_back_to_back_space();
    test_unsupported();
`ifdef KEYER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
